sha2_round_engine: RTL and testbench
====================================

# sha2_round_engine

Iterative SHA-2 compression engine for the Versat datapath, generalising the fixed 32-bit T1/T2 round stage to a full multi-round compression. It supports SHA-256 (`DATA_W`=32) and SHA-512 (`DATA_W`=64). It accepts K/W words through a valid/ready handshake and applies one round per accepted pair. After the last round it adds the working state back into the chaining value. Chained runs allow multi-block messages without reloading state.

## Interface
- `DATA_W`, 32: word width. Only 32 (SHA-256 functions) and 64 (SHA-512 functions) are legal. Any other value is an elaboration error.
- `ROUNDS`, 64: rounds per block. Use 64 for SHA-256 and 80 for SHA-512. Legal range is 1..255.
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `run`  in  1  single-cycle start pulse. It is sampled only in IDLE.
- `chain`  in  1  sampled with `run`.
  - 1: start from the current `h_out`.
  - 0: start from `h_in`.
- `h_in`  in  8*DATA_W  initial chaining value. Word a is at [DATA_W-1:0] and word h is at the top.
- `kw_valid`  in  1  `k_in`/`w_in` are valid.
- `kw_ready`  out  1  engine accepts a K/W pair this cycle.
- `k_in`  in  DATA_W  round constant.
- `w_in`  in  DATA_W  message schedule word.
- `busy`  out  1  high from the cycle after an accepted `run` until `done`, inclusive.
- `done`  out  1  one-cycle pulse. `h_out` is valid in this cycle.
- `h_out`  out  8*DATA_W  digest/chaining result, same packing as `h_in`. It holds its value until the next FINAL.

## Operation
- States: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - On `run`, load working registers a..h and base register `hb`. The source is `h_out` if `chain`=1, otherwise `h_in`.
  - Clear the round counter `rc` and go to ROUND.
- ROUND:
  - `kw_ready`=1.
  - On `kw_valid`&&`kw_ready`, compute T1 = h+Σ1(e)+Ch(e,f,g)+k+w and T2 = Σ0(a)+Maj(a,b,c).
  - Update: a←T1+T2, b←a, c←b, d←c, e←d+T1, f←e, g←f, h←g. Increment `rc`.
  - A handshake with `rc`=ROUNDS-1 moves to FINAL. Without a handshake, state and `rc` hold.
- FINAL:
  - `kw_ready`=0.
  - `h_out` word i ← `hb`[i]+work[i]. Go to DONE.
- DONE: `done`=1 and `busy`=1. Go to IDLE.
- Arithmetic: all additions are modulo 2^DATA_W and carries are discarded. Ch = (e&f)^(~e&g). Maj = (a&b)^(a&c)^(b&c).
- Σ rotations:
  - DATA_W=32: Σ0 = ROTR 2,13,22; Σ1 = ROTR 6,11,25.
  - DATA_W=64: Σ0 = ROTR 28,34,39; Σ1 = ROTR 14,18,41.
- `run` outside IDLE is ignored, with no queueing.
- `kw_valid` outside ROUND is ignored and no data is consumed.
- `chain`=1 before any completed run starts from `h_out`=0. This is legal and deterministic.
- Reset while active:
  - Every register clears immediately and the state returns to IDLE.
  - The partial block is lost and no `done` is produced.

## Timing
- Reset values: `kw_ready`=0, `busy`=0, `done`=0, `h_out`=0. Working registers, `hb` and `rc` are all 0. State is IDLE.
- With `run` at cycle 0 and `kw_valid` held high:
  - Rounds execute in cycles 1..ROUNDS.
  - FINAL is at cycle ROUNDS+1.
  - `done` and the new `h_out` appear in cycle ROUNDS+2.
  - Total latency is ROUNDS+2.
- Each cycle with `kw_valid`=0 during ROUND adds exactly one cycle.
- `kw_ready` is a function of state only. It never depends combinationally on `kw_valid`.
- The earliest next `run` is accepted in the cycle after `done`, when the state is IDLE.

## Structure
- Package `sha2_pkg` contains:
  - the state enum;
  - SHA-256 and SHA-512 IV constants, used only by benches;
  - rotation amounts selected by DATA_W;
  - functions `rotr`, `big_sigma0` and `big_sigma1`.
- Sub-module `sha2_round_logic` (parameter DATA_W):
  - purely combinational;
  - inputs a..h, k, w; outputs next a and next e.
  - It is the direct successor of the existing T1/T2 pair.
- The top level holds the FSM, counter, working/base registers and feed-forward adders.

## Test plan
- SHA-256 "abc": IV on `h_in`, `chain`=0, standard K with the padded-block W schedule, `kw_valid` held high → `done` at cycle 66. `h_out`[31:0]=0xba7816bf and `h_out`[255:224]=0xf20015ad.
- SHA-512 "abc" (DATA_W=64, ROUNDS=80): IV plus K/W schedule → `done` at cycle 82. Word a = 0xddaf35a193617aba and word h = 0x2a9ac94fa54ca49f.
- Backpressure: repeat the SHA-256 "abc" case with `kw_valid` toggling every cycle → same digest, `done` at cycle 130, and `rc` never advances without a handshake.
- Chaining: two-block "abcdbcdecdefdefg…nopq" with block 1 using `chain`=0 and block 2 using `chain`=1 → final word a=0x248d6a61 and word h=0x19db06c1.
- Reset mid-run: assert `rst` low after the 30th handshake → all outputs read 0 immediately. A fresh SHA-256 "abc" run afterwards gives the correct digest.
- `run` pulsed during ROUND and during DONE → ignored. The digest is unchanged and exactly one `done` pulse occurs per accepted `run`.

Source files
------------

// File: rtl/sha2_pkg.sv
// sha2_pkg: shared definitions for the SHA-2 round engine.
//   - sha2_state_t : engine FSM states
//   - SHA256_IV / SHA512_IV : standard initial hash values, word a in the
//     low bits, matching the h_in/h_out packing
//   - rot_amt / rotr / big_sigma0 / big_sigma1 : Σ functions. All values
//     travel as 64 bits; in 32-bit mode only bits [31:0] are meaningful.
package sha2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } sha2_state_t;

    localparam logic [255:0] SHA256_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [511:0] SHA512_IV = {
        64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b,
        64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
        64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b,
        64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908
    };

    // sel 0..2 are the Σ0 rotations, sel 3..5 the Σ1 rotations.
    function automatic logic [7:0] rot_amt(input bit wide, input logic [2:0] sel);
        logic [7:0] amt;
        amt = 8'd0;
        case (sel)
            3'd0:    amt = wide ? 8'd28 : 8'd2;
            3'd1:    amt = wide ? 8'd34 : 8'd13;
            3'd2:    amt = wide ? 8'd39 : 8'd22;
            3'd3:    amt = wide ? 8'd14 : 8'd6;
            3'd4:    amt = wide ? 8'd18 : 8'd11;
            3'd5:    amt = wide ? 8'd41 : 8'd25;
            default: amt = 8'd0;
        endcase
        return amt;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input logic [7:0] n,
                                         input bit wide);
        logic [63:0] r;
        if (wide)
            r = (x >> n) | (x << (8'd64 - n));
        else
            r = {32'h0, (x[31:0] >> n) | (x[31:0] << (8'd32 - n))};
        return r;
    endfunction

    function automatic logic [63:0] big_sigma0(input logic [63:0] x, input bit wide);
        return rotr(x, rot_amt(wide, 3'd0), wide) ^
               rotr(x, rot_amt(wide, 3'd1), wide) ^
               rotr(x, rot_amt(wide, 3'd2), wide);
    endfunction

    function automatic logic [63:0] big_sigma1(input logic [63:0] x, input bit wide);
        return rotr(x, rot_amt(wide, 3'd3), wide) ^
               rotr(x, rot_amt(wide, 3'd4), wide) ^
               rotr(x, rot_amt(wide, 3'd5), wide);
    endfunction

endpackage

// File: rtl/sha2_round_logic.sv
// sha2_round_logic: one combinational SHA-2 round (T1/T2 stage).
//   in : a..h  working words, k round constant, w schedule word
//   out: a_next = T1+T2, e_next = d+T1 (the only two words that are not a
//        plain shift of the working set)
module sha2_round_logic
    import sha2_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] e,
    input  logic [DATA_W-1:0] f,
    input  logic [DATA_W-1:0] g,
    input  logic [DATA_W-1:0] h,
    input  logic [DATA_W-1:0] k,
    input  logic [DATA_W-1:0] w,
    output logic [DATA_W-1:0] a_next,
    output logic [DATA_W-1:0] e_next
);

    localparam bit WIDE = (DATA_W == 64);

    logic [DATA_W-1:0] s0, s1, ch, maj, t1, t2;

    always_comb begin
        s0     = DATA_W'(big_sigma0(64'(a), WIDE));
        s1     = DATA_W'(big_sigma1(64'(e), WIDE));
        ch     = (e & f) ^ (~e & g);
        maj    = (a & b) ^ (a & c) ^ (b & c);
        t1     = h + s1 + ch + k + w;
        t2     = s0 + maj;
        a_next = t1 + t2;
        e_next = d + t1;
    end

endmodule

// File: rtl/sha2_round_engine.sv
// sha2_round_engine: iterative SHA-2 compression (SHA-256 / SHA-512).
//   clk, rst      : clock, asynchronous active-low reset
//   run, chain    : start pulse (IDLE only); chain=1 starts from h_out
//   h_in          : initial chaining value, word a at [DATA_W-1:0]
//   kw_valid/ready: one round per accepted K/W pair (k_in, w_in)
//   busy          : engine active (ROUND..DONE)
//   done, h_out   : one-cycle completion pulse, digest held until next FINAL
module sha2_round_engine
    import sha2_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  chain,
    input  logic [8*DATA_W-1:0]   h_in,
    input  logic                  kw_valid,
    output logic                  kw_ready,
    input  logic [DATA_W-1:0]     k_in,
    input  logic [DATA_W-1:0]     w_in,
    output logic                  busy,
    output logic                  done,
    output logic [8*DATA_W-1:0]   h_out
);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("sha2_round_engine: DATA_W must be 32 or 64");
    end
    if (ROUNDS < 1 || ROUNDS > 255) begin : g_bad_rounds
        $error("sha2_round_engine: ROUNDS must be in 1..255");
    end

    localparam logic [7:0] LAST_RC = 8'(ROUNDS - 1);

    sha2_state_t state, state_nxt;

    // Index 0 is word a, index 7 is word h.
    logic [7:0][DATA_W-1:0] work;
    logic [7:0][DATA_W-1:0] hb;
    logic [7:0][DATA_W-1:0] h_q;
    logic [7:0][DATA_W-1:0] h_in_w;
    logic [7:0][DATA_W-1:0] start_val;
    logic [7:0]             rc;
    logic [DATA_W-1:0]      a_next, e_next;
    logic                   kw_fire;

    assign h_in_w    = h_in;
    assign start_val = chain ? h_q : h_in_w;
    assign kw_fire   = kw_valid && kw_ready;
    assign h_out     = h_q;

    sha2_round_logic #(
        .DATA_W (DATA_W)
    ) u_round (
        .a      (work[0]),
        .b      (work[1]),
        .c      (work[2]),
        .d      (work[3]),
        .e      (work[4]),
        .f      (work[5]),
        .g      (work[6]),
        .h      (work[7]),
        .k      (k_in),
        .w      (w_in),
        .a_next (a_next),
        .e_next (e_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Handshake outputs decode state only, so kw_ready never depends on
    // kw_valid combinationally.
    always_comb begin
        state_nxt = state;
        kw_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (run) state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                kw_ready = 1'b1;
                if (kw_fire && rc == LAST_RC) state_nxt = ST_FINAL;
            end
            ST_FINAL: state_nxt = ST_DONE;
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work <= '0;
            hb   <= '0;
            h_q  <= '0;
            rc   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        work <= start_val;
                        hb   <= start_val;
                        rc   <= '0;
                    end
                end
                ST_ROUND: begin
                    if (kw_fire) begin
                        // h<-g, g<-f, f<-e, e<-d+T1, d<-c, c<-b, b<-a, a<-T1+T2
                        work <= {work[6], work[5], work[4], e_next,
                                 work[2], work[1], work[0], a_next};
                        rc   <= rc + 8'd1;
                    end
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++) h_q[i] <= hb[i] + work[i];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_round_engine.sv
// Self-checking bench for sha2_round_engine: SHA-256 and SHA-512 instances,
// known-answer digests, backpressure, chaining, reset abort, ignored run
// pulses and randomized K/W/h_in against a FIPS-style reference model.
module tb_sha2_round_engine;
    import sha2_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, run32, run64, chain, kw_valid;
    logic [511:0] h_in;
    logic [63:0]  k_in, w_in;
    logic         kw_ready32, busy32, done32;
    logic         kw_ready64, busy64, done64;
    logic [255:0] h_out32;
    logic [511:0] h_out64;

    sha2_round_engine #(.DATA_W(32), .ROUNDS(64)) u32 (
        .clk(clk), .rst(rst), .run(run32), .chain(chain), .h_in(h_in[255:0]),
        .kw_valid(kw_valid), .kw_ready(kw_ready32), .k_in(k_in[31:0]),
        .w_in(w_in[31:0]), .busy(busy32), .done(done32), .h_out(h_out32)
    );

    sha2_round_engine #(.DATA_W(64), .ROUNDS(80)) u64 (
        .clk(clk), .rst(rst), .run(run64), .chain(chain), .h_in(h_in),
        .kw_valid(kw_valid), .kw_ready(kw_ready64), .k_in(k_in),
        .w_in(w_in), .busy(busy64), .done(done64), .h_out(h_out64)
    );

    int errs = 0;
    int checks = 0;

    logic [63:0]  kc [80];   // SHA-512 K, computed from cube roots of primes
    logic [63:0]  kt [80];   // K fed to the DUT
    logic [63:0]  wt [80];   // W fed to the DUT
    logic [63:0]  mb [16];   // message block words
    logic [511:0] prev32, prev64;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit wide);
        return wide ? kw_ready64 : kw_ready32;
    endfunction
    function automatic logic bsy(input bit wide);
        return wide ? busy64 : busy32;
    endfunction
    function automatic logic dn(input bit wide);
        return wide ? done64 : done32;
    endfunction
    function automatic logic [511:0] hout(input bit wide);
        return wide ? h_out64 : {256'h0, h_out32};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [63:0] rr(input logic [63:0] x, input int n, input bit wide);
        logic [31:0] x32;
        x32 = x[31:0];
        if (wide) return (x >> n) | (x << (64 - n));
        return {32'h0, (x32 >> n) | (x32 << (32 - n))};
    endfunction
    function automatic logic [63:0] shr(input logic [63:0] x, input int n, input bit wide);
        logic [31:0] x32;
        x32 = x[31:0];
        return wide ? (x >> n) : {32'h0, x32 >> n};
    endfunction
    function automatic logic [63:0] bs0(input logic [63:0] x, input bit wide);
        return wide ? rr(x, 28, 1) ^ rr(x, 34, 1) ^ rr(x, 39, 1)
                    : rr(x, 2, 0) ^ rr(x, 13, 0) ^ rr(x, 22, 0);
    endfunction
    function automatic logic [63:0] bs1(input logic [63:0] x, input bit wide);
        return wide ? rr(x, 14, 1) ^ rr(x, 18, 1) ^ rr(x, 41, 1)
                    : rr(x, 6, 0) ^ rr(x, 11, 0) ^ rr(x, 25, 0);
    endfunction
    function automatic logic [63:0] ls0(input logic [63:0] x, input bit wide);
        return wide ? rr(x, 1, 1) ^ rr(x, 8, 1) ^ shr(x, 7, 1)
                    : rr(x, 7, 0) ^ rr(x, 18, 0) ^ shr(x, 3, 0);
    endfunction
    function automatic logic [63:0] ls1(input logic [63:0] x, input bit wide);
        return wide ? rr(x, 19, 1) ^ rr(x, 61, 1) ^ shr(x, 6, 1)
                    : rr(x, 17, 0) ^ rr(x, 19, 0) ^ shr(x, 10, 0);
    endfunction

    function automatic logic [511:0] model(input logic [511:0] iv, input bit wide, input int rounds);
        logic [63:0]  m, t1, t2, ivw;
        logic [63:0]  v [8];
        logic [511:0] r;
        m = wide ? 64'hffff_ffff_ffff_ffff : 64'hffff_ffff;
        for (int i = 0; i < 8; i++)
            v[i] = wide ? iv[64*i +: 64] : {32'h0, iv[32*i +: 32]};
        for (int t = 0; t < rounds; t++) begin
            t1 = (v[7] + bs1(v[4], wide) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[t] + wt[t]) & m;
            t2 = (bs0(v[0], wide) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]))) & m;
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = (v[4] + t1) & m;
            v[0] = (t1 + t2) & m;
        end
        r = '0;
        for (int i = 0; i < 8; i++) begin
            ivw = wide ? iv[64*i +: 64] : {32'h0, iv[32*i +: 32]};
            if (wide) r[64*i +: 64] = (v[i] + ivw) & m;
            else      r[32*i +: 32] = 32'((v[i] + ivw) & m);
        end
        return r;
    endfunction

    function automatic logic [63:0] cbrt_frac(input int p);
        logic [255:0] tgt, lo, hi, mid;
        tgt = 256'(p) << 192;
        lo  = '0;
        hi  = 256'(1) << 68;
        while (hi - lo > 1) begin
            mid = (lo + hi) >> 1;
            if (mid * mid * mid <= tgt) lo = mid;
            else                        hi = mid;
        end
        return lo[63:0];
    endfunction

    function automatic void init_k();
        int p, cnt;
        bit prime;
        cnt = 0;
        p = 2;
        while (cnt < 80) begin
            prime = 1'b1;
            for (int d = 2; d * d <= p; d++) if (p % d == 0) prime = 1'b0;
            if (prime) begin
                kc[cnt] = cbrt_frac(p);
                cnt++;
            end
            p++;
        end
    endfunction

    // SHA-256 K is the top half of the matching SHA-512 K.
    function automatic void load_k(input bit wide);
        for (int i = 0; i < 80; i++) kt[i] = wide ? kc[i] : {32'h0, kc[i][63:32]};
    endfunction

    function automatic void load_rand();
        for (int i = 0; i < 80; i++) begin
            kt[i] = {$urandom, $urandom};
            wt[i] = {$urandom, $urandom};
        end
    endfunction

    function automatic void load_abc(input bit wide);
        for (int i = 0; i < 16; i++) mb[i] = '0;
        mb[0]  = wide ? 64'h6162_6380_0000_0000 : 64'h6162_6380;
        mb[15] = 64'd24;
    endfunction

    function automatic void load_two(input int blk);
        string s;
        s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        for (int i = 0; i < 14; i++)
            mb[i] = (blk == 1) ? {32'h0, s[4*i], s[4*i+1], s[4*i+2], s[4*i+3]} : 64'h0;
        mb[14] = (blk == 1) ? 64'h8000_0000 : 64'h0;
        mb[15] = (blk == 1) ? 64'h0 : 64'd448;
    endfunction

    function automatic void sched(input bit wide);
        logic [63:0] m;
        m = wide ? 64'hffff_ffff_ffff_ffff : 64'hffff_ffff;
        for (int t = 0; t < 80; t++) begin
            if (t < 16) wt[t] = mb[t] & m;
            else wt[t] = (ls1(wt[t-2], wide) + wt[t-7] + ls0(wt[t-15], wide) + wt[t-16]) & m;
        end
    endfunction

    // mode: 0 kw_valid held high, 1 toggling (low first), 2 random.
    // abort_at >= 0 pulls reset low once that many rounds were accepted.
    // poke drives run during ROUND and during DONE; both must be ignored.
    task automatic run_block(input bit wide, input logic [511:0] hin, input bit chn,
                             input int mode, input int abort_at, input bit poke,
                             input string tag, input logic [511:0] exp, input int exp_cyc);
        int rounds, idx, stall, bad, dcyc, extra;
        bit v, exp_rdy;
        logic [511:0] hd;
        rounds = wide ? 80 : 64;
        idx = 0; stall = 0; bad = 0; dcyc = -1; extra = 0; hd = '0;
        @(negedge clk);
        h_in = hin; chain = chn;
        kw_valid = 1'b1;                       // ignored while IDLE
        k_in = {$urandom, $urandom};
        w_in = {$urandom, $urandom};
        if (wide) run64 = 1'b1; else run32 = 1'b1;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            run32 = 1'b0; run64 = 1'b0; h_in = hin; chain = chn;
            exp_rdy = (idx < rounds);
            if (rdy(wide) !== exp_rdy || bsy(wide) !== 1'b1) bad++;
            if (dn(wide) === 1'b1) begin
                dcyc = c;
                hd = hout(wide);
                if (poke) begin
                    if (wide) run64 = 1'b1; else run32 = 1'b1;
                end
                break;
            end
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b0;
                #1;
                chk({tag, "_rst_ready"}, 512'(rdy(wide)), 512'(0));
                chk({tag, "_rst_busy"},  512'(bsy(wide)), 512'(0));
                chk({tag, "_rst_done"},  512'(dn(wide)),  512'(0));
                chk({tag, "_rst_hout"},  hout(wide), 512'(0));
                @(negedge clk);
                rst = 1'b1;
                kw_valid = 1'b0;
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (c % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            kw_valid = v;
            if (exp_rdy) begin
                k_in = kt[idx];
                w_in = wt[idx];
            end else begin
                k_in = {$urandom, $urandom};
                w_in = {$urandom, $urandom};
            end
            if (poke && c == 10) begin
                if (wide) run64 = 1'b1; else run32 = 1'b1;
                chain = ~chn;
                h_in = {16{$urandom}};
            end
            if (exp_rdy) begin
                if (v) idx++;
                else   stall++;
            end
        end
        for (int q = 0; q < 5; q++) begin
            @(negedge clk);
            run32 = 1'b0; run64 = 1'b0; kw_valid = 1'b0;
            if (dn(wide) !== 1'b0 || bsy(wide) !== 1'b0) extra++;
        end
        chk({tag, "_digest"}, hd, exp);
        chk({tag, "_cycle"}, 512'(dcyc), 512'(exp_cyc >= 0 ? exp_cyc : rounds + 2 + stall));
        chk({tag, "_ctl"}, 512'(bad), 512'(0));
        chk({tag, "_quiet"}, 512'(extra), 512'(0));
        if (wide) prev64 = exp; else prev32 = exp;
    endtask

    initial begin
        logic [511:0] e, e1, hr;
        bit chn;
        rst = 1'b0; run32 = 1'b0; run64 = 1'b0; chain = 1'b0; kw_valid = 1'b0;
        h_in = '0; k_in = '0; w_in = '0;
        prev32 = '0; prev64 = '0;
        init_k();
        repeat (3) @(negedge clk);
        chk("reset_ready32", 512'(kw_ready32), 512'(0));
        chk("reset_busy32",  512'(busy32), 512'(0));
        chk("reset_done32",  512'(done32), 512'(0));
        chk("reset_hout32",  512'(h_out32), 512'(0));
        chk("reset_busy64",  512'(busy64), 512'(0));
        chk("reset_hout64",  h_out64, 512'(0));
        rst = 1'b1;

        // SHA-256 "abc"
        load_k(0); load_abc(0); sched(0);
        e = model(512'(SHA256_IV), 0, 64);
        run_block(0, 512'(SHA256_IV), 0, 0, -1, 0, "abc256", e, 66);
        chk("abc256_word_a", 512'(h_out32[31:0]),    512'(32'hba7816bf));
        chk("abc256_word_h", 512'(h_out32[255:224]), 512'(32'hf20015ad));

        // Backpressure: valid toggling, low first
        run_block(0, 512'(SHA256_IV), 0, 1, -1, 0, "abc256_bp", e, 130);

        // Reset after the 30th handshake, then a clean run
        run_block(0, 512'(SHA256_IV), 0, 0, 30, 0, "abort", e, -1);
        prev32 = '0; prev64 = '0;
        run_block(0, 512'(SHA256_IV), 0, 0, -1, 0, "fresh", e, 66);

        // run during ROUND and DONE is ignored; random valid gaps
        run_block(0, 512'(SHA256_IV), 0, 2, -1, 1, "poke", e, -1);

        // Two-block message with chaining; h_in garbage on block 2
        load_two(1); sched(0);
        e1 = model(512'(SHA256_IV), 0, 64);
        run_block(0, 512'(SHA256_IV), 0, 0, -1, 0, "blk1", e1, 66);
        load_two(2); sched(0);
        e = model(e1, 0, 64);
        run_block(0, {16{$urandom}}, 1, 2, -1, 0, "blk2", e, -1);
        chk("blk2_word_a", 512'(h_out32[31:0]),    512'(32'h248d6a61));
        chk("blk2_word_h", 512'(h_out32[255:224]), 512'(32'h19db06c1));

        // chain=1 right after reset starts from zero
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        prev32 = '0; prev64 = '0;
        load_rand();
        e = model(prev32, 0, 64);
        run_block(0, {16{$urandom}}, 1, 2, -1, 0, "chain0", e, -1);

        // Random 32-bit runs
        for (int i = 0; i < 3; i++) begin
            load_rand();
            hr  = {16{$urandom}};
            chn = 1'($urandom_range(0, 1));
            e   = model(chn ? prev32 : hr, 0, 64);
            run_block(0, hr, chn, 2, -1, 0, $sformatf("rnd32_%0d", i), e, -1);
        end

        // SHA-512 "abc"
        load_k(1); load_abc(1); sched(1);
        e = model(SHA512_IV, 1, 80);
        run_block(1, SHA512_IV, 0, 0, -1, 0, "abc512", e, 82);
        chk("abc512_word_a", 512'(h_out64[63:0]),    512'(64'hddaf35a193617aba));
        chk("abc512_word_h", 512'(h_out64[511:448]), 512'(64'h2a9ac94fa54ca49f));

        // Random 64-bit chained run with ignored run pulses
        load_rand();
        e = model(prev64, 1, 80);
        run_block(1, {16{$urandom}}, 1, 2, -1, 1, "rnd64", e, -1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
